mips_run_ctrl: RTL and testbench

//   Run/load sequencer for the single-cycle MIPS core. Streams a program from a

---
 rtl/mips_run_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// Run/load sequencer for the single-cycle MIPS core: streams a host program into
// instruction memory, then holds, runs, single-steps or halts the core.
module mips_run_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 32,
  parameter int MAX_CYC = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LD_START,
  input  logic [ADDR_W:0]   LD_COUNT,
  input  logic              LD_VALID,
  input  logic [31:0]       LD_DATA,
  output logic              LD_READY,
  input  logic              CMD_RUN,
  input  logic              CMD_STEP,
  input  logic              CMD_HALT,
  input  logic              BRK_EN,
  input  logic [31:0]       BRK_PC,
  input  logic [31:0]       PC,
  output logic              CPU_RST,
  output logic              CPU_CE,
  output logic              WE,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [31:0]       W_Ins,
  output logic [2:0]        STATE,
  output logic              LOADED,
  output logic              BRK_HIT,
  output logic [CNT_W-1:0]  CYCLES
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]  MAX_WORDS   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] WDOG_LIMIT  = CNT_W'(MAX_CYC);
  localparam bit               WDOG_ON     = (MAX_CYC != 0);

  state_t              state_q, state_d;
  logic                ld_ready_q, ld_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [31:0]         w_ins_q, w_ins_d;
  logic                loaded_q, loaded_d;
  logic                brk_hit_q, brk_hit_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic                resume_q, resume_d;

  logic                brk_match;
  logic                wdog_stop;
  logic                run_stop;
  logic                ce;
  logic                beat;
  logic [ADDR_W:0]     ld_cnt_clamped;

  // CE is decoded from the registered state and masked by same-cycle stop
  // conditions, so the instruction sitting at a breakpoint never executes.
  always_comb begin
    brk_match      = BRK_EN && (PC == BRK_PC) && !resume_q;
    wdog_stop      = WDOG_ON && (run_cnt_q >= WDOG_LIMIT);
    run_stop       = CMD_HALT || brk_match || wdog_stop;
    ce             = ((state_q == S_RUN) && !run_stop) ||
                     ((state_q == S_STEP) && !CMD_HALT);
    beat           = ld_ready_q && LD_VALID;
    ld_cnt_clamped = (LD_COUNT > MAX_WORDS) ? MAX_WORDS : LD_COUNT;
  end

  always_comb begin
    state_d    = state_q;
    ld_ready_d = ld_ready_q;
    we_d       = 1'b0;
    w_addr_d   = w_addr_q;
    w_ins_d    = w_ins_q;
    loaded_d   = loaded_q;
    brk_hit_d  = 1'b0;
    cycles_d   = (ce && (cycles_q != '1)) ? cycles_q + 1'b1 : cycles_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    run_cnt_d  = (ce && (run_cnt_q != '1)) ? run_cnt_q + 1'b1 : run_cnt_q;
    resume_d   = resume_q;

    case (state_q)
      S_IDLE: begin
        if (LD_START) begin
          state_d    = S_LOAD;
          cnt_d      = ld_cnt_clamped;
          idx_d      = '0;
          loaded_d   = 1'b0;
          ld_ready_d = (ld_cnt_clamped != '0);
        end else if (loaded_q && (CMD_STEP || CMD_RUN)) begin
          if (CMD_HALT) begin
            state_d = S_HALT;
          end else if (CMD_STEP) begin
            state_d = S_STEP;
          end else begin
            state_d   = S_RUN;
            run_cnt_d = '0;
            resume_d  = 1'b0;
          end
        end
      end

      S_LOAD: begin
        if (cnt_q == '0) begin
          state_d    = S_IDLE;
          loaded_d   = 1'b1;
          cycles_d   = '0;
          ld_ready_d = 1'b0;
        end else if (beat) begin
          we_d     = 1'b1;
          w_addr_d = idx_q[ADDR_W-1:0];
          w_ins_d  = LD_DATA;
          idx_d    = idx_q + 1'b1;
          if ((idx_q + 1'b1) == cnt_q) begin
            state_d    = S_IDLE;
            loaded_d   = 1'b1;
            cycles_d   = '0;
            ld_ready_d = 1'b0;
          end
        end
      end

      S_RUN: begin
        resume_d = 1'b0;
        if (run_stop) begin
          state_d   = S_HALT;
          brk_hit_d = !CMD_HALT && brk_match;
        end
      end

      S_STEP: begin
        state_d = S_HALT;
      end

      S_HALT: begin
        if (CMD_HALT) begin
          state_d = S_HALT;
        end else if (LD_START) begin
          state_d    = S_LOAD;
          cnt_d      = ld_cnt_clamped;
          idx_d      = '0;
          loaded_d   = 1'b0;
          ld_ready_d = (ld_cnt_clamped != '0);
        end else if (CMD_STEP) begin
          state_d = S_STEP;
        end else if (CMD_RUN) begin
          state_d   = S_RUN;
          run_cnt_d = '0;
          resume_d  = 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        ld_ready_d = 1'b0;
      end
    endcase

    cpu_rst_d = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_HALT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      ld_ready_q <= 1'b0;
      we_q       <= 1'b0;
      w_addr_q   <= '0;
      w_ins_q    <= '0;
      loaded_q   <= 1'b0;
      brk_hit_q  <= 1'b0;
      cycles_q   <= '0;
      cpu_rst_q  <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      run_cnt_q  <= '0;
      resume_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= ld_ready_d;
      we_q       <= we_d;
      w_addr_q   <= w_addr_d;
      w_ins_q    <= w_ins_d;
      loaded_q   <= loaded_d;
      brk_hit_q  <= brk_hit_d;
      cycles_q   <= cycles_d;
      cpu_rst_q  <= cpu_rst_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      run_cnt_q  <= run_cnt_d;
      resume_q   <= resume_d;
    end
  end

  assign STATE    = state_q;
  assign LD_READY = ld_ready_q;
  assign WE       = we_q;
  assign W_ADDR   = w_addr_q;
  assign W_Ins    = w_ins_q;
  assign LOADED   = loaded_q;
  assign BRK_HIT  = brk_hit_q;
  assign CYCLES   = cycles_q;
  assign CPU_RST  = cpu_rst_q;
  assign CPU_CE   = ce;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: a small PC model stands in for the core,
// and queues hold the expected memory writes and executed PCs.
module tb_mips_run_ctrl;

  localparam int ADDR_W  = 3;
  localparam int CNT_W   = 4;
  localparam int MAX_CYC = 5;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              LD_START = 1'b0;
  logic [ADDR_W:0]   LD_COUNT = '0;
  logic              LD_VALID = 1'b0;
  logic [31:0]       LD_DATA = '0;
  logic              LD_READY;
  logic              CMD_RUN = 1'b0;
  logic              CMD_STEP = 1'b0;
  logic              CMD_HALT = 1'b0;
  logic              BRK_EN = 1'b0;
  logic [31:0]       BRK_PC = '0;
  logic [31:0]       pc = '0;
  logic              CPU_RST;
  logic              CPU_CE;
  logic              WE;
  logic [ADDR_W-1:0] W_ADDR;
  logic [31:0]       W_Ins;
  logic [2:0]        STATE;
  logic              LOADED;
  logic              BRK_HIT;
  logic [CNT_W-1:0]  CYCLES;

  int checks    = 0;
  int errors    = 0;
  int brk_count = 0;

  logic [ADDR_W+31:0] exp_wr_q[$];
  logic [31:0]        exp_pc_q[$];
  logic [31:0]        prog[16];

  mips_run_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_CYC(MAX_CYC)) dut (
    .CLK(CLK), .RST(RST),
    .LD_START(LD_START), .LD_COUNT(LD_COUNT), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
    .LD_READY(LD_READY),
    .CMD_RUN(CMD_RUN), .CMD_STEP(CMD_STEP), .CMD_HALT(CMD_HALT),
    .BRK_EN(BRK_EN), .BRK_PC(BRK_PC), .PC(pc),
    .CPU_RST(CPU_RST), .CPU_CE(CPU_CE), .WE(WE), .W_ADDR(W_ADDR), .W_Ins(W_Ins),
    .STATE(STATE), .LOADED(LOADED), .BRK_HIT(BRK_HIT), .CYCLES(CYCLES)
  );

  always #5 CLK = ~CLK;

  // Core stand-in: PC advances by one word on every enabled cycle.
  always @(posedge CLK) begin
    if (!CPU_RST) pc <= '0;
    else if (CPU_CE) pc <= pc + 32'd4;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (WE) begin
      if (exp_wr_q.size() == 0) checkOutput("we_unexpected", 64'd1, 64'd0);
      else checkOutput("write", {W_ADDR, W_Ins}, exp_wr_q.pop_front());
    end
    if (CPU_CE) begin
      if (exp_pc_q.size() == 0) checkOutput("ce_unexpected", 64'd1, 64'd0);
      else checkOutput("ce_pc", pc, exp_pc_q.pop_front());
    end
    if (BRK_HIT) brk_count++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic run, input logic step, input logic halt);
    CMD_RUN = run; CMD_STEP = step; CMD_HALT = halt;
    tick();
    CMD_RUN = 1'b0; CMD_STEP = 1'b0; CMD_HALT = 1'b0;
  endtask

  task automatic loadWords(input int count_req, input int beats, input int base);
    int guard;
    LD_START = 1'b1;
    LD_COUNT = (ADDR_W+1)'(count_req);
    tick();
    LD_START = 1'b0;
    for (int i = 0; i < beats; i++) begin
      LD_VALID = 1'b1;
      LD_DATA  = prog[base+i];
      guard = 0;
      while (!LD_READY && guard < 20) begin tick(); guard++; end
      checkOutput("ld_ready", LD_READY, 1);
      exp_wr_q.push_back({ADDR_W'(i), prog[base+i]});
      tick();
    end
    LD_VALID = 1'b0;
  endtask

  task automatic waitState(input logic [2:0] s, input int budget);
    int n = 0;
    while (STATE !== s && n < budget) begin tick(); n++; end
    checkOutput("wait_state", STATE, s);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    prog[0] = 32'h20080005; prog[1] = 32'h20090003; prog[2] = 32'h01095020;
    for (int i = 3; i < 16; i++) prog[i] = 32'hA5000000 + i;

    repeat (3) tick();
    RST = 1'b1;
    tick();
    checkOutput("rst_state", STATE, 0);
    checkOutput("rst_cpu_rst", CPU_RST, 0);
    checkOutput("rst_ce", CPU_CE, 0);
    checkOutput("rst_we", WE, 0);
    checkOutput("rst_ready", LD_READY, 0);
    checkOutput("rst_loaded", LOADED, 0);
    checkOutput("rst_cycles", CYCLES, 0);

    // Run before any program is loaded is ignored.
    CMD_RUN = 1'b1;
    repeat (3) tick();
    CMD_RUN = 1'b0;
    checkOutput("noload_state", STATE, 0);
    checkOutput("noload_cpu_rst", CPU_RST, 0);

    // Reset in the middle of a 4-word load.
    loadWords(4, 2, 8);
    tick();
    @(negedge CLK); #1;
    RST = 1'b0;
    tick();
    checkOutput("midrst_state", STATE, 0);
    checkOutput("midrst_loaded", LOADED, 0);
    checkOutput("midrst_we", WE, 0);
    checkOutput("midrst_ready", LD_READY, 0);
    checkOutput("midrst_waddr", W_ADDR, 0);
    checkOutput("midrst_wins", W_Ins, 0);
    checkOutput("midrst_wr_q", exp_wr_q.size(), 0);
    RST = 1'b1;
    repeat (2) tick();
    checkOutput("midrst_stale_we", WE, 0);

    // Three-word program load.
    loadWords(3, 3, 0);
    tick();
    checkOutput("load_loaded", LOADED, 1);
    checkOutput("load_state", STATE, 0);
    checkOutput("load_ready", LD_READY, 0);
    checkOutput("load_wr_q", exp_wr_q.size(), 0);

    // Breakpoint at 0x8 stops before that instruction executes.
    BRK_EN = 1'b1; BRK_PC = 32'h8;
    exp_pc_q.push_back(32'h0); exp_pc_q.push_back(32'h4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState(3'd4, 20);
    tick();
    checkOutput("brk_hits", brk_count, 1);
    checkOutput("brk_cycles", CYCLES, 2);
    checkOutput("brk_pc", pc, 32'h8);
    checkOutput("brk_cpu_rst", CPU_RST, 1);
    checkOutput("brk_pc_q", exp_pc_q.size(), 0);

    // Single step over the breakpoint.
    exp_pc_q.push_back(32'h8);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("step_state", STATE, 4);
    checkOutput("step_cycles", CYCLES, 3);
    checkOutput("step_pc", pc, 32'hC);
    checkOutput("step_pc_q", exp_pc_q.size(), 0);

    // Resume on the breakpoint PC: no re-trap, then watchdog stops after 5.
    BRK_PC = 32'hC;
    for (int i = 0; i < 5; i++) exp_pc_q.push_back(32'hC + 32'(4*i));
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState(3'd4, 20);
    tick();
    checkOutput("wdog_cycles", CYCLES, 8);
    checkOutput("wdog_pc", pc, 32'h20);
    checkOutput("wdog_hits", brk_count, 1);
    checkOutput("wdog_pc_q", exp_pc_q.size(), 0);

    // Step and halt together: halt wins, no CE.
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("stephalt_state", STATE, 4);
    checkOutput("stephalt_cycles", CYCLES, 8);

    // Halt request during a run takes effect on the cycle it is seen.
    BRK_EN = 1'b0;
    exp_pc_q.push_back(32'h20); exp_pc_q.push_back(32'h24);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("halt_state", STATE, 4);
    tick();
    checkOutput("halt_cycles", CYCLES, 10);
    checkOutput("halt_pc", pc, 32'h28);

    // Cycle counter reaches all-ones and holds there.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) exp_pc_q.push_back(32'h28 + 32'(20*r) + 32'(4*i));
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitState(3'd4, 20);
      tick();
      checkOutput("sat_cycles", CYCLES, 4'hF);
    end
    checkOutput("sat_pc_q", exp_pc_q.size(), 0);

    // Zero-length load from HALT.
    loadWords(0, 0, 0);
    checkOutput("zero_state_load", STATE, 1);
    checkOutput("zero_loaded_clr", LOADED, 0);
    checkOutput("zero_cpu_rst", CPU_RST, 0);
    tick();
    checkOutput("zero_state_idle", STATE, 0);
    checkOutput("zero_loaded", LOADED, 1);
    checkOutput("zero_cycles", CYCLES, 0);

    // Oversized load clamps to the memory depth.
    loadWords(12, 8, 3);
    checkOutput("clamp_ready", LD_READY, 0);
    checkOutput("clamp_loaded", LOADED, 1);
    LD_VALID = 1'b1;
    repeat (2) tick();
    LD_VALID = 1'b0;
    tick();
    checkOutput("clamp_wr_q", exp_wr_q.size(), 0);
    checkOutput("clamp_state", STATE, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
